// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its two-requester arbiter front end.
package alu_pkg;

    localparam int DATA_W    = 16;
    localparam int OP_W      = 4;
    localparam int NUM_FLAGS = 5;

    localparam int FLG_CB = 4;
    localparam int FLG_Z  = 3;
    localparam int FLG_S  = 2;
    localparam int FLG_C  = 1;
    localparam int FLG_P  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_INC  = 4'h8,
        OP_DEC  = 4'h9,
        OP_ASR  = 4'hA,
        OP_ROL  = 4'hB,
        OP_ROR  = 4'hC,
        OP_NAND = 4'hD,
        OP_NOR  = 4'hE,
        OP_XNOR = 4'hF
    } op_e;

endpackage

// File: rtl/alu_16_bit.sv
// Clocked ALU: combinational op decode followed by LAT register stages on result and flags.
module alu_16_bit #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] q_out,
    output logic              carry_borrow,
    output logic              zero,
    output logic              sign,
    output logic              carry_flag,
    output logic              parity
);
    import alu_pkg::*;

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W:0] ONE = 1;

    op_e                           op_sel;
    logic [DATA_W:0]               sum;
    logic [DATA_W-1:0]             res_d;
    logic [NUM_FLAGS-1:0]          flags_d;
    logic                          cb;
    logic                          cf;
    logic [LAT-1:0][DATA_W-1:0]    data_pipe_q;
    logic [LAT-1:0][NUM_FLAGS-1:0] flag_pipe_q;

    assign op_sel = op_e'(op);

    // Arithmetic ops run one bit wide so the top bit is carry (add) or borrow (sub).
    always_comb begin
        sum   = '0;
        res_d = '0;
        cb    = 1'b0;
        cf    = 1'b0;
        case (op_sel)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                res_d = sum[MSB:0];
                cb    = sum[DATA_W];
            end
            OP_SUB: begin
                sum   = {1'b0, a} - {1'b0, b};
                res_d = sum[MSB:0];
                cb    = sum[DATA_W];
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_NOT:  res_d = ~a;
            OP_SHL: begin
                res_d = {a[MSB-1:0], 1'b0};
                cf    = a[MSB];
            end
            OP_SHR: begin
                res_d = {1'b0, a[MSB:1]};
                cf    = a[0];
            end
            OP_INC: begin
                sum   = {1'b0, a} + ONE;
                res_d = sum[MSB:0];
                cb    = sum[DATA_W];
            end
            OP_DEC: begin
                sum   = {1'b0, a} - ONE;
                res_d = sum[MSB:0];
                cb    = sum[DATA_W];
            end
            OP_ASR: begin
                res_d = {a[MSB], a[MSB:1]};
                cf    = a[0];
            end
            OP_ROL: begin
                res_d = {a[MSB-1:0], a[MSB]};
                cf    = a[MSB];
            end
            OP_ROR: begin
                res_d = {a[0], a[MSB:1]};
                cf    = a[0];
            end
            OP_NAND: res_d = ~(a & b);
            OP_NOR:  res_d = ~(a | b);
            OP_XNOR: res_d = ~(a ^ b);
            default: res_d = '0;
        endcase

        flags_d         = '0;
        flags_d[FLG_CB] = cb;
        flags_d[FLG_Z]  = (res_d == '0);
        flags_d[FLG_S]  = res_d[MSB];
        flags_d[FLG_C]  = cf;
        flags_d[FLG_P]  = ^res_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_pipe_q <= '0;
            flag_pipe_q <= '0;
        end else begin
            data_pipe_q[0] <= res_d;
            flag_pipe_q[0] <= flags_d;
            for (int i = 1; i < LAT; i++) begin
                data_pipe_q[i] <= data_pipe_q[i-1];
                flag_pipe_q[i] <= flag_pipe_q[i-1];
            end
        end
    end

    assign q_out        = data_pipe_q[LAT-1];
    assign carry_borrow = flag_pipe_q[LAT-1][FLG_CB];
    assign zero         = flag_pipe_q[LAT-1][FLG_Z];
    assign sign         = flag_pipe_q[LAT-1][FLG_S];
    assign carry_flag   = flag_pipe_q[LAT-1][FLG_C];
    assign parity       = flag_pipe_q[LAT-1][FLG_P];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one clocked ALU between two valid/ready requesters,
// one operation in flight at a time, result returned to the issuing requester.
module alu_arbiter #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int OP_W    = alu_pkg::OP_W,
    parameter int ALU_LAT = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req0_valid,
    output logic                            req0_ready,
    input  logic [DATA_W-1:0]               req0_a,
    input  logic [DATA_W-1:0]               req0_b,
    input  logic [OP_W-1:0]                 req0_op,
    input  logic                            req1_valid,
    output logic                            req1_ready,
    input  logic [DATA_W-1:0]               req1_a,
    input  logic [DATA_W-1:0]               req1_b,
    input  logic [OP_W-1:0]                 req1_op,
    output logic                            rsp0_valid,
    input  logic                            rsp0_ready,
    output logic                            rsp1_valid,
    input  logic                            rsp1_ready,
    output logic [DATA_W-1:0]               rsp_data,
    output logic [alu_pkg::NUM_FLAGS-1:0]   rsp_flags,
    output logic                            busy
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(ALU_LAT + 1);

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   owner_q, owner_d;
    logic [DATA_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]      b_q, b_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [CNT_W-1:0]       exec_cnt_q, exec_cnt_d;
    logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
    logic [NUM_FLAGS-1:0]   rsp_flags_q, rsp_flags_d;

    logic                   grant0, grant1;
    logic [DATA_W-1:0]      alu_q;
    logic [NUM_FLAGS-1:0]   alu_flags;
    logic                   alu_cb, alu_z, alu_s, alu_c, alu_p;

    alu_16_bit #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .LAT    (ALU_LAT)
    ) u_alu (
        .clk          (clk),
        .rst_n        (reset),
        .a            (a_q),
        .b            (b_q),
        .op           (op_q),
        .q_out        (alu_q),
        .carry_borrow (alu_cb),
        .zero         (alu_z),
        .sign         (alu_s),
        .carry_flag   (alu_c),
        .parity       (alu_p)
    );

    assign alu_flags = {alu_cb, alu_z, alu_s, alu_c, alu_p};

    // last_grant_q names the requester that won the previous contest; the other wins a tie.
    always_comb begin
        grant0       = req0_valid && (!req1_valid || last_grant_q);
        grant1       = req1_valid && (!req0_valid || !last_grant_q);

        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        exec_cnt_d   = exec_cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d        = grant1 ? req1_a  : req0_a;
                    b_d        = grant1 ? req1_b  : req0_b;
                    op_d       = grant1 ? req1_op : req0_op;
                    owner_d    = grant1;
                    exec_cnt_d = CNT_W'(ALU_LAT);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // One cycle for operands to reach the ALU plus ALU_LAT register stages.
                if (exec_cnt_q == '0) begin
                    rsp_data_d  = alu_q;
                    rsp_flags_d = alu_flags;
                    state_d     = RESP;
                end else begin
                    exec_cnt_d = exec_cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            exec_cnt_q   <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            exec_cnt_q   <= exec_cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign req0_ready = reset && (state_q == IDLE) && grant0;
    assign req1_ready = reset && (state_q == IDLE) && grant1;
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign busy       = (state_q != IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the 16-bit clocked ALU. It owns one `alu_16_bit` instance and shares it between two independent requesters using round-robin arbitration. It accepts one operation at a time over a valid/ready handshake, sequences operands through the ALU, captures the result and status flags, and returns them to the requester that issued the operation. It sits between the datapath control units and the ALU; no other block drives the ALU directly.

## Interface
Parameters:
- `DATA_W`, 16, operand/result width (must match ALU)
- `OP_W`, 4, opcode width
- `ALU_LAT`, 1, ALU register latency in cycles (operands stable → `q_out` valid)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; also drives the ALU's reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_a`, `req0_b`  in  DATA_W  requester 0 operands
- `req0_op`  in  OP_W  requester 0 opcode (passed to ALU unmodified)
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`  same as above, for requester 1
- `rsp0_valid`  out  1  result for requester 0 available
- `rsp0_ready`  in  1  requester 0 consumes result
- `rsp1_valid`, `rsp1_ready`  same as above, for requester 1
- `rsp_data`  out  DATA_W  captured ALU `q_out`
- `rsp_flags`  out  5  captured {carry_borrow, zero, sign, carry_flag, parity}
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant goes to the requester with valid set.
  - If both are valid, grant goes to the requester that did not win last (`last_grant` pointer).
  - `reqN_ready` = (state==IDLE) && grantN. It is combinational and at most one is high.
  - On the edge where valid&&ready: latch a/b/op into the operand registers, record the owner, and load `exec_cnt` = ALU_LAT. Next state is EXEC.
- **EXEC**
  - Operand registers drive the ALU and are held constant.
  - `exec_cnt` decrements each cycle. After ALU_LAT+1 cycles in EXEC, capture `q_out` into `rsp_data` and the flags into `rsp_flags`. Next state is RESP.
- **RESP**
  - `rspN_valid` is high for the owner only.
  - `rsp_data`/`rsp_flags` stay stable until rspN_valid && rspN_ready.
  - On that handshake: `last_grant` ← owner, next state IDLE.
- Only one operation is outstanding at a time. Back-to-back throughput is one operation per ALU_LAT+3 cycles when responses are consumed immediately.
- A requester that is not granted must hold valid and payload stable. The arbiter does not sample its payload until the grant.
- `rspM_ready` for a non-owner is ignored.
- In RESP, `rsp_data` and `rsp_flags` show the captured values. Outside RESP they retain their last values and are don't-care to consumers.
- Reset (asynchronous, `reset`=0):
  - state IDLE; all ready/valid outputs 0; `busy` 0.
  - operand registers, `rsp_data` and `rsp_flags` are 0.
  - `last_grant` = 1, so requester 0 wins the first contended cycle.
- Reset mid-operation: the pending operation is discarded and no response is issued. After reset release, the requester must re-present the operation.

## Timing
With ALU_LAT=1 and acceptance at edge 0:
- Cycles 1–2: EXEC.
- Capture at edge 2.
- `rsp_valid` is high from cycle 3.
- If `rsp_ready` is high in cycle 3, the FSM is in IDLE in cycle 4, and a new acceptance can occur at the end of cycle 4.
- General case: `rsp_valid` rises ALU_LAT+2 cycles after the accept edge.
- `reqN_ready` is never high while `busy`=1.
- `rsp0_valid` and `rsp1_valid` are never high together.

## Structure
- Shared package `alu_pkg`:
  - DATA_W, OP_W
  - flag bit index constants (FLG_CB=4, FLG_Z=3, FLG_S=2, FLG_C=1, FLG_P=0)
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2
- Single sub-module: `alu_16_bit`, instantiated once as `u_alu`.
- Arbitration, FSM and capture registers live in `alu_arbiter`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with both valids high → all ready/valid outputs 0, `busy` 0. Release reset → requester 0 is granted in the first IDLE cycle.
- **Single op:** req0 with a=16'd10, b=16'd5, op=4'h1 → `req0_ready` pulses 1 cycle; `rsp0_valid` goes high exactly 3 cycles later. `rsp_data`/`rsp_flags` must equal a standalone reference `alu_16_bit` driven with the same inputs. `rsp1_valid` stays 0.
- **Contention:** both valid continuously with rsp ready tied high, opcodes swept 4'h0..4'hF → grants alternate 0,1,0,1…, responses route to the matching `rspN_valid`, and one operation completes every 4 cycles.
- **Response backpressure:** `rsp1_ready`=0 for 10 cycles → `rsp1_valid`, `rsp_data` and `busy` are held and `req0_ready` stays 0. When ready rises, IDLE is reached the next cycle.
- **Mid-op reset:** assert reset during EXEC → outputs clear asynchronously before the next edge, and no `rsp_valid` is seen for the aborted operation.
- **Payload stability:** change `req1_a` while req1 is waiting behind req0 → the result reflects the value present at req1's accept edge.
